basic_and_driver: RTL

Transmitter end of the toggle-encoded (pulse-as-edge) interface of the clocked AND cell model. Accepts one operand pair per valid/ready request and emits the toggle sequence a, then b, then cell clock, each separated by a programmable gap. It then observes the cell output toggle and returns the decoded AND result plus error flags. It sits between a level-domain test sequencer and the cell under test; cycle counts map to cell timing via the simulation timescale.

---
 rtl/basic_and_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/basic_and_driver.sv
// Toggle-encoded driver for the clocked AND cell model.
// Sends a, b, clk pulses as line inversions and decodes the out toggle.
module basic_and_driver #(
  parameter int unsigned SEP_CYC       = 4,
  parameter int unsigned OUT_WAIT_CYC  = 8,
  parameter int unsigned INIT_WAIT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_a,
  input  logic req_b,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_and,
  output logic rsp_mismatch,
  output logic rsp_spurious,
  output logic dut_a,
  output logic dut_b,
  output logic dut_clk,
  input  logic dut_out
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRV_A,
    S_DRV_B,
    S_DRV_CLK,
    S_WAIT_OUT,
    S_RESP
  } state_t;

  localparam logic [7:0] SEP_M1  = 8'(SEP_CYC - 1);
  localparam logic [7:0] OUT_M1  = 8'(OUT_WAIT_CYC - 1);
  localparam logic [7:0] INIT_LD = 8'(INIT_WAIT_CYC);

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic       r_op_a, w_op_a;
  logic       r_op_b, w_op_b;
  logic       r_spur, w_spur;
  logic       r_out_ref, w_out_ref;
  logic       r_dut_a, w_dut_a;
  logic       r_dut_b, w_dut_b;
  logic       r_dut_clk, w_dut_clk;
  logic       r_rsp_and, w_rsp_and;
  logic       r_rsp_mis, w_rsp_mis;
  logic       r_rsp_spur, w_rsp_spur;
  logic       w_out_chg;

  assign w_out_chg    = dut_out ^ r_out_ref;
  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_and      = r_rsp_and;
  assign rsp_mismatch = r_rsp_mis;
  assign rsp_spurious = r_rsp_spur;
  assign dut_a        = r_dut_a;
  assign dut_b        = r_dut_b;
  assign dut_clk      = r_dut_clk;

  // Sequencing: each line inversion is registered on entry to its slot.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_op_a     = r_op_a;
    w_op_b     = r_op_b;
    w_spur     = r_spur;
    w_out_ref  = r_out_ref;
    w_dut_a    = r_dut_a;
    w_dut_b    = r_dut_b;
    w_dut_clk  = r_dut_clk;
    w_rsp_and  = r_rsp_and;
    w_rsp_mis  = r_rsp_mis;
    w_rsp_spur = r_rsp_spur;
    unique case (r_state)
      S_INIT: begin
        if (r_cnt != 8'd0) w_cnt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) w_state = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          w_op_a    = req_a;
          w_op_b    = req_b;
          w_spur    = 1'b0;
          w_out_ref = dut_out;
          w_dut_a   = r_dut_a ^ req_a;
          w_cnt     = SEP_M1;
          w_state   = S_DRV_A;
        end
      end
      S_DRV_A: begin
        if (w_out_chg) begin
          w_spur    = 1'b1;
          w_out_ref = dut_out;
        end
        if (r_cnt == 8'd0) begin
          w_dut_b = r_dut_b ^ r_op_b;
          w_cnt   = SEP_M1;
          w_state = S_DRV_B;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_DRV_B: begin
        if (w_out_chg) begin
          w_spur    = 1'b1;
          w_out_ref = dut_out;
        end
        if (r_cnt == 8'd0) begin
          w_dut_clk = ~r_dut_clk;
          w_state   = S_DRV_CLK;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_DRV_CLK: begin
        w_cnt   = OUT_M1;
        w_state = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (r_cnt == 8'd0) begin
          w_rsp_and  = w_out_chg;
          w_rsp_mis  = w_out_chg ^ (r_op_a & r_op_b);
          w_rsp_spur = r_spur;
          w_state    = S_RESP;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state = S_IDLE;
      end
      default: w_state = S_INIT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_cnt      <= INIT_LD;
      r_op_a     <= 1'b0;
      r_op_b     <= 1'b0;
      r_spur     <= 1'b0;
      r_out_ref  <= dut_out;
      r_dut_a    <= 1'b0;
      r_dut_b    <= 1'b0;
      r_dut_clk  <= 1'b0;
      r_rsp_and  <= 1'b0;
      r_rsp_mis  <= 1'b0;
      r_rsp_spur <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_op_a     <= w_op_a;
      r_op_b     <= w_op_b;
      r_spur     <= w_spur;
      r_out_ref  <= w_out_ref;
      r_dut_a    <= w_dut_a;
      r_dut_b    <= w_dut_b;
      r_dut_clk  <= w_dut_clk;
      r_rsp_and  <= w_rsp_and;
      r_rsp_mis  <= w_rsp_mis;
      r_rsp_spur <= w_rsp_spur;
    end
  end

endmodule
